// File: rtl/gray_pkg.sv
// Shared types and helpers for gray-coded counter crossings.
// Gray/binary helpers work on 64-bit values; callers cast to their width.
package gray_pkg;

   localparam int W_DEFAULT       = 8;
   localparam int SYNC_STAGES_MIN = 2;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      TRACK
   } state_t;

   // Zero-extended input decodes identically in the low bits.
   function automatic logic [63:0] g2b(input logic [63:0] g);
      logic [63:0] b;
      b[63] = g[63];
      for (int i = 62; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic is_one_hot(input logic [63:0] d);
      return (d != 64'd0) && ((d & (d - 64'd1)) == 64'd0);
   endfunction

endpackage

// File: rtl/gray_sync.sv
// N-stage flop synchronizer bank for gray-coded buses.
// Shared by every gray pointer crossing into the local clock.
module gray_sync
   import gray_pkg::*;
#(
   parameter int W      = W_DEFAULT,
   parameter int STAGES = SYNC_STAGES_MIN
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s [STAGES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < STAGES; k++) begin
            s[k] <= '0;
         end
      end else begin
         s[0] <= d;
         for (int k = 1; k < STAGES; k++) begin
            s[k] <= s[k-1];
         end
      end
   end

   assign q = s[STAGES-1];

endmodule

// File: rtl/gray_rx_mon.sv
// Gray counter receive monitor: sync, decode, classify each change.
// Define GRAY_ERR_CNT_EN to build the saturating error counter.
module gray_rx_mon
   import gray_pkg::*;
#(
   parameter int W           = W_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         clr_err,
   input  logic [W-1:0] gray_in,
   output logic [W-1:0] bin_out,
   output logic         step_valid,
   output logic         step_up,
   output logic         err_pulse,
   output logic         err_sticky,
   output logic [7:0]   err_cnt
);

   state_t       state;
   logic [W-1:0] sg;
   logic [W-1:0] sg_bin;
   logic [W-1:0] g_q;
   logic [W-1:0] b_q;
   logic [W-1:0] d;
   logic         one_bit;
   logic         up;
   logic         err_now;

   gray_sync #(
      .W      (W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gray_in),
      .q   (sg)
   );

   assign sg_bin  = W'(g2b(64'(sg)));
   assign d       = sg ^ g_q;
   assign one_bit = is_one_hot(64'(d));
   assign up      = (sg_bin == W'(b_q + W'(1)));
   assign err_now = (state == TRACK) && enable
                    && (d != '0) && !one_bit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         g_q        <= '0;
         b_q        <= '0;
         step_valid <= 1'b0;
         step_up    <= 1'b0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         step_valid <= 1'b0;
         err_pulse  <= 1'b0;
         // A fresh error outranks a coincident clear.
         if (err_now) begin
            err_sticky <= 1'b1;
         end else if (clr_err) begin
            err_sticky <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (enable) state <= PRIME;
            end
            PRIME: begin
               g_q   <= sg;
               b_q   <= sg_bin;
               state <= enable ? TRACK : IDLE;
            end
            TRACK: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (d != '0) begin
                  g_q        <= sg;
                  b_q        <= sg_bin;
                  step_valid <= one_bit;
                  err_pulse  <= !one_bit;
                  if (one_bit) step_up <= up;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bin_out = b_q;

`ifdef GRAY_ERR_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 8'd0;
      end else if (err_now) begin
         if (clr_err) begin
            cnt_q <= 8'd1;
         end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end else if (clr_err) begin
         cnt_q <= 8'd0;
      end
   end

   assign err_cnt = cnt_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_gray_rx_mon.sv
// Randomised bench for gray_rx_mon against a cycle reference model.
// Honours GRAY_ERR_CNT_EN for the expected error count.
module tb_gray_rx_mon;

   localparam int W  = 8;
   localparam int SS = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         enable = 1'b0;
   logic         clr_err = 1'b0;
   logic [W-1:0] gray_in = 8'h07;
   logic [W-1:0] bin_out;
   logic         step_valid;
   logic         step_up;
   logic         err_pulse;
   logic         err_sticky;
   logic [7:0]   err_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] pipe [SS];
   int         mstate;
   logic [7:0] ref_g;
   logic [7:0] e_bin;
   logic [7:0] e_cnt;
   logic       e_sv;
   logic       e_up;
   logic       e_ep;
   logic       e_st;
   logic [7:0] cur_b;

   gray_rx_mon #(
      .W           (W),
      .SYNC_STAGES (SS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clr_err    (clr_err),
      .gray_in    (gray_in),
      .bin_out    (bin_out),
      .step_valid (step_valid),
      .step_up    (step_up),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // Binary bit i is the parity of all gray bits at or above i.
   function automatic logic [7:0] dec(input logic [7:0] g);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   function automatic logic [7:0] enc(input logic [7:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < SS; k++) pipe[k] = 8'h00;
      mstate = 0;
      ref_g  = 8'h00;
      e_bin  = 8'h00;
      e_cnt  = 8'h00;
      e_sv   = 1'b0;
      e_up   = 1'b0;
      e_ep   = 1'b0;
      e_st   = 1'b0;
   endtask

   task automatic model_edge();
      logic [7:0] sg;
      logic [7:0] nb;
      int         n;
      sg   = pipe[SS-1];
      e_sv = 1'b0;
      e_ep = 1'b0;
      if (clr_err) begin
         e_st  = 1'b0;
         e_cnt = 8'h00;
      end
      case (mstate)
         0: if (enable) mstate = 1;
         1: begin
            ref_g  = sg;
            e_bin  = dec(sg);
            mstate = enable ? 2 : 0;
         end
         default: begin
            if (!enable) begin
               mstate = 0;
            end else if (sg != ref_g) begin
               n  = $countones(sg ^ ref_g);
               nb = dec(sg);
               if (n == 1) begin
                  e_sv = 1'b1;
                  e_up = (nb == 8'(e_bin + 8'd1));
               end else begin
                  e_ep = 1'b1;
                  e_st = 1'b1;
`ifdef GRAY_ERR_CNT_EN
                  if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
`endif
               end
               ref_g = sg;
               e_bin = nb;
            end
         end
      endcase
      for (int k = SS-1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = gray_in;
   endtask

   task automatic check_all();
      chk("bin_out",    32'(bin_out),    32'(e_bin));
      chk("step_valid", 32'(step_valid), 32'(e_sv));
      chk("step_up",    32'(step_up),    32'(e_up));
      chk("err_pulse",  32'(err_pulse),  32'(e_ep));
      chk("err_sticky", 32'(err_sticky), 32'(e_st));
      chk("err_cnt",    32'(err_cnt),    32'(e_cnt));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic cycles(input int n);
      repeat (n) cyc();
   endtask

   task automatic reprime(input logic [7:0] g);
      enable  = 1'b0;
      gray_in = g;
      cur_b   = dec(g);
      cycles(4);
      enable = 1'b1;
      cycles(4);
   endtask

   initial begin
      logic [31:0] exp_cnt;
`ifdef GRAY_ERR_CNT_EN
      exp_cnt = 32'd1;
`else
      exp_cnt = 32'd0;
`endif
      model_reset();
      gray_in = 8'h07;
      cur_b   = dec(8'h07);
      #7;
      check_all();

      // 1: prime on a stable 0x07
      @(negedge clk);
      rst = 1'b1;
      cycles(3);
      enable = 1'b1;
      cycles(4);
      chk("t1_bin", 32'(bin_out), 32'd5);
      chk("t1_err", 32'(err_sticky), 32'd0);

      // 2/3: single steps up then down
      gray_in = 8'h05;
      cycles(5);
      chk("t2_bin", 32'(bin_out), 32'd6);
      chk("t2_up", 32'(step_up), 32'd1);
      gray_in = 8'h07;
      cycles(5);
      chk("t3_bin", 32'(bin_out), 32'd5);
      chk("t3_up", 32'(step_up), 32'd0);

      // 4: wrap 255 -> 0
      reprime(8'h80);
      chk("t4_bin255", 32'(bin_out), 32'd255);
      gray_in = 8'h00;
      cycles(5);
      chk("t4_bin0", 32'(bin_out), 32'd0);
      chk("t4_up", 32'(step_up), 32'd1);
      chk("t4_err", 32'(err_sticky), 32'd0);

      // 5: two-bit change, then clear coinciding with an error
      reprime(8'h07);
      gray_in = 8'h04;
      cycles(5);
      chk("t5_bin", 32'(bin_out), 32'd7);
      chk("t5_sticky", 32'(err_sticky), 32'd1);
      gray_in = 8'h07;
      cycles(2);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      chk("t5_pulse2", 32'(err_pulse), 32'd1);
      chk("t5_sticky2", 32'(err_sticky), 32'd1);
      chk("t5_cnt", 32'(err_cnt), exp_cnt);
      cycles(2);

      // random traffic
      cur_b = dec(gray_in);
      for (int it = 0; it < 1500; it++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 70) begin
            cur_b = ($urandom_range(0, 1) == 1) ? 8'(cur_b + 8'd1)
                                                : 8'(cur_b - 8'd1);
         end else if (r < 82) begin
            cur_b = 8'($urandom);
         end else if (r < 87) begin
            enable = ~enable;
         end
         gray_in = enc(cur_b);
         clr_err = ($urandom_range(0, 15) == 0);
         cycles($urandom_range(1, 4));
      end
      clr_err = 1'b0;

      // 6: async reset mid-track, then re-prime on 0x80
      reprime(8'h33);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_bin", 32'(bin_out), 32'd0);
      chk("t6_sv", 32'(step_valid), 32'd0);
      chk("t6_up", 32'(step_up), 32'd0);
      chk("t6_ep", 32'(err_pulse), 32'd0);
      chk("t6_st", 32'(err_sticky), 32'd0);
      chk("t6_cnt", 32'(err_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      rst     = 1'b1;
      gray_in = 8'h80;
      enable  = 1'b1;
      cycles(6);
      chk("t6_bin255", 32'(bin_out), 32'd255);
      chk("t6_noerr", 32'(err_sticky), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
